// File: rtl/operand_serializer.sv
// Bit-serial source: parallel-loads two WIDTH-bit operands and streams them LSB first, one bit per cycle.
// First bit appears the cycle after start; stall holds the current bit with bit_valid low, and done follows the last bit.
module operand_serializer #(
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [WIDTH-1:0] op_a_in,
  input  logic [WIDTH-1:0] op_b_in,
  input  logic          start,
  input  logic          stall,
  output logic          busy,
  output logic          bit_valid,
  output logic          a_bit,
  output logic          b_bit,
  output logic [IW-1:0] bit_index,
  output logic          first_bit,
  output logic          last_bit,
  output logic          done
);

  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]    idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      // Operands are only writable while idle, so a stream never sees them change.
      if (state == IDLE && load_en) begin
        a_reg <= op_a_in;
        b_reg <= op_b_in;
      end
      if (state == SHIFT) begin
        if (!stall) begin
          idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
      end else begin
        idx <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (!stall && idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    bit_valid = (state == SHIFT) && !stall;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    if (state == SHIFT) begin
      a_bit = a_reg[idx];
      b_bit = b_reg[idx];
    end
    bit_index = idx;
    first_bit = bit_valid && (idx == '0);
    last_bit  = bit_valid && (idx == LAST_IDX);
    done      = (state == DONE);
  end

endmodule

// File: tb/tb_operand_serializer.sv
// Directed bench for operand_serializer: inputs change 1 ns after the rising edge, outputs sampled on the falling edge.
module tb_operand_serializer;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_en = 1'b0;
  logic [7:0] op_a_in = 8'h00;
  logic [7:0] op_b_in = 8'h00;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       busy, bit_valid, a_bit, b_bit, first_bit, last_bit, done;
  logic [2:0] bit_index;

  int compared   = 0;
  int mismatched = 0;

  operand_serializer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .op_a_in(op_a_in), .op_b_in(op_b_in),
    .start(start), .stall(stall), .busy(busy), .bit_valid(bit_valid), .a_bit(a_bit),
    .b_bit(b_bit), .bit_index(bit_index), .first_bit(first_bit), .last_bit(last_bit),
    .done(done)
  );

  always #5 clk = ~clk;

  // {busy, bit_valid, a_bit, b_bit, bit_index, first_bit, last_bit, done}
  function automatic logic [9:0] obs();
    return {busy, bit_valid, a_bit, b_bit, bit_index, first_bit, last_bit, done};
  endfunction

  function automatic logic [9:0] exp_bit(input logic [7:0] a, input logic [7:0] b, input int i);
    return {1'b1, 1'b1, a[i], b[i], 3'(i), (i == 0), (i == 7), 1'b0};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first SHIFT cycle (bit 0), before its falling edge.
  task automatic load_start(input logic [7:0] a, input logic [7:0] b);
    next_cycle();
    op_a_in = a;
    op_b_in = b;
    load_en = 1'b1;
    next_cycle();
    load_en = 1'b0;
    start   = 1'b1;
    next_cycle();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (obs() !== 10'h000) begin
      mismatched++;
      $display("FAIL reset_outputs got=%h want=%h", obs(), 10'h000);
    end
  endtask

  task automatic test_basic();
    load_start(8'hA5, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk);
      compared++;
      if (obs() !== exp_bit(8'hA5, 8'h3C, i)) begin
        mismatched++;
        $display("FAIL basic_bit%0d got=%h want=%h", i, obs(), exp_bit(8'hA5, 8'h3C, i));
      end
    end
    next_cycle();
    @(negedge clk);
    compared++;
    if ({busy, bit_valid, done, a_bit, b_bit} !== 5'b10100) begin
      mismatched++;
      $display("FAIL basic_done got=%b want=%b", {busy, bit_valid, done, a_bit, b_bit}, 5'b10100);
    end
    next_cycle();
    @(negedge clk);
    compared++;
    if (obs() !== 10'h000) begin
      mismatched++;
      $display("FAIL basic_idle got=%h want=%h", obs(), 10'h000);
    end
  endtask

  task automatic test_stall();
    logic [9:0] held;
    held = {1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
    load_start(8'hA5, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      if (i == 4) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          if (s > 0) next_cycle();
          @(negedge clk);
          compared++;
          if (obs() !== held) begin
            mismatched++;
            $display("FAIL stall_hold%0d got=%h want=%h", s, obs(), held);
          end
        end
        next_cycle();
        stall = 1'b0;
      end
      @(negedge clk);
      compared++;
      if (obs() !== exp_bit(8'hA5, 8'h3C, i)) begin
        mismatched++;
        $display("FAIL stall_bit%0d got=%h want=%h", i, obs(), exp_bit(8'hA5, 8'h3C, i));
      end
    end
    next_cycle();
    @(negedge clk);
    compared++;
    if ({busy, bit_valid, done} !== 3'b101) begin
      mismatched++;
      $display("FAIL stall_done got=%b want=%b", {busy, bit_valid, done}, 3'b101);
    end
    next_cycle();
    @(negedge clk);
    compared++;
    if (obs() !== 10'h000) begin
      mismatched++;
      $display("FAIL stall_idle got=%h want=%h", obs(), 10'h000);
    end
  endtask

  task automatic test_ignored_controls();
    int active;
    load_start(8'hA5, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      if (i == 2) begin
        op_a_in = 8'hFF;
        load_en = 1'b1;
        start   = 1'b1;
      end else begin
        load_en = 1'b0;
        start   = 1'b0;
      end
      @(negedge clk);
      compared++;
      if (obs() !== exp_bit(8'hA5, 8'h3C, i)) begin
        mismatched++;
        $display("FAIL ignored_bit%0d got=%h want=%h", i, obs(), exp_bit(8'hA5, 8'h3C, i));
      end
    end
    next_cycle();
    @(negedge clk);
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL ignored_done got=%b want=1", done);
    end
    active = 0;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      @(negedge clk);
      if (busy || done) active++;
    end
    compared++;
    if (active !== 0) begin
      mismatched++;
      $display("FAIL ignored_no_second_stream busy_or_done_cycles=%0d want=0", active);
    end
  endtask

  task automatic test_same_cycle_load_start();
    next_cycle();
    op_a_in = 8'h81;
    op_b_in = 8'h00;
    load_en = 1'b1;
    start   = 1'b1;
    next_cycle();
    load_en = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk);
      compared++;
      if (obs() !== exp_bit(8'h81, 8'h00, i)) begin
        mismatched++;
        $display("FAIL same_cycle_bit%0d got=%h want=%h", i, obs(), exp_bit(8'h81, 8'h00, i));
      end
    end
    next_cycle();
    @(negedge clk);
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL same_cycle_done got=%b want=1", done);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int active;
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      if (i == 3) rst = 1'b1;
      @(negedge clk);
      compared++;
      if (obs() !== exp_bit(8'h81, 8'h00, i)) begin
        mismatched++;
        $display("FAIL rstmid_bit%0d got=%h want=%h", i, obs(), exp_bit(8'h81, 8'h00, i));
      end
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (obs() !== 10'h000) begin
      mismatched++;
      $display("FAIL rstmid_cleared got=%h want=%h", obs(), 10'h000);
    end
    active = 0;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      @(negedge clk);
      if (busy || done) active++;
    end
    compared++;
    if (active !== 0) begin
      mismatched++;
      $display("FAIL rstmid_no_done busy_or_done_cycles=%0d want=0", active);
    end
    load_start(8'h5A, 8'hC3);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk);
      compared++;
      if (obs() !== exp_bit(8'h5A, 8'hC3, i)) begin
        mismatched++;
        $display("FAIL rstmid_reload_bit%0d got=%h want=%h", i, obs(), exp_bit(8'h5A, 8'hC3, i));
      end
    end
    next_cycle();
    @(negedge clk);
    compared++;
    if ({busy, done} !== 2'b11) begin
      mismatched++;
      $display("FAIL rstmid_reload_done got=%b want=11", {busy, done});
    end
  endtask

  // Entered in the DONE cycle of the 0x5A/0xC3 stream.
  task automatic test_back_to_back();
    int dones;
    next_cycle();
    start = 1'b1;
    @(negedge clk);
    compared++;
    if (obs() !== 10'h000) begin
      mismatched++;
      $display("FAIL b2b_bubble got=%h want=%h", obs(), 10'h000);
    end
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk);
      compared++;
      if (obs() !== exp_bit(8'h5A, 8'hC3, i)) begin
        mismatched++;
        $display("FAIL b2b_bit%0d got=%h want=%h", i, obs(), exp_bit(8'h5A, 8'hC3, i));
      end
    end
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      @(negedge clk);
      if (done) dones++;
    end
    compared++;
    if (dones !== 1) begin
      mismatched++;
      $display("FAIL b2b_done_count got=%0d want=1", dones);
    end
    compared++;
    if (obs() !== 10'h000) begin
      mismatched++;
      $display("FAIL b2b_final_idle got=%h want=%h", obs(), 10'h000);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_ignored_controls();
    test_same_cycle_load_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
